program_loader: RTL and testbench

Copies a program image, one word per clock, from a synchronous-read storage port into one 512-word slot of the writable instruction memory. It sits between the storage array and the instruction memory write port. The OS (slot 0) uses it to place user programs in slots 1–3 before jumping to them. It is the writer for the memory that the fetch stage reads by PC.

---
 rtl/program_loader_pkg.sv | 25 ++
 rtl/program_loader.sv | 97 +++++++++
 tb/tb_program_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants and FSM state type for the program loader.
// The instruction memory is divided into 512-word slots.
package program_loader_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 13;
  localparam int SLOT_BITS      = 9;
  localparam int SLOT_IDX_WIDTH = ADDR_WIDTH - SLOT_BITS;

  // Slots in use: the OS plus three user programs. The Dst_Slot field is wider than this.
  localparam int SLOT_COUNT = 4;

  localparam logic [SLOT_IDX_WIDTH-1:0] SLOT_OS    = 4'd0;
  localparam logic [SLOT_IDX_WIDTH-1:0] SLOT_PROG1 = 4'd1;
  localparam logic [SLOT_IDX_WIDTH-1:0] SLOT_PROG2 = 4'd2;
  localparam logic [SLOT_IDX_WIDTH-1:0] SLOT_PROG3 = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    COPY,
    FINISH
  } state_t;

endpackage

// File: rtl/program_loader.sv
// Copies Word_Count storage words (clamped to one slot) into an instruction memory slot,
// one word per clock, priming the one-cycle storage read latency first.
module program_loader #(
  parameter int DATA_WIDTH = program_loader_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = program_loader_pkg::ADDR_WIDTH,
  parameter int SLOT_BITS  = program_loader_pkg::SLOT_BITS
) (
  input  logic                          Fast_Clock,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic [ADDR_WIDTH-1:0]         Src_Base,
  input  logic [ADDR_WIDTH-SLOT_BITS-1:0] Dst_Slot,
  input  logic [SLOT_BITS:0]            Word_Count,
  output logic [ADDR_WIDTH-1:0]         Src_Addr,
  input  logic [DATA_WIDTH-1:0]         Src_Data,
  output logic                          Mem_Write,
  output logic [ADDR_WIDTH-1:0]         Mem_Addr,
  output logic [DATA_WIDTH-1:0]         Mem_Data,
  output logic                          Busy,
  output logic                          Done,
  output program_loader_pkg::state_t    Dbg_State
);
  import program_loader_pkg::*;

  // Request handshake: Start is a request that is taken only on an edge where Busy is
  // low (state IDLE); there is no ready back-pressure and nothing is queued while Busy.

  localparam logic [SLOT_BITS:0] MAX_WORDS = (SLOT_BITS + 1)'(1) << SLOT_BITS;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-SLOT_BITS-1:0] slot_q;
  logic [SLOT_BITS:0]              n_q;
  logic [SLOT_BITS:0]              cnt_q;
  logic [SLOT_BITS:0]              n_clamped;
  logic                            issue;

  assign n_clamped = (Word_Count > MAX_WORDS) ? MAX_WORDS : Word_Count;

  // COPY lasts N+1 cycles: N issue cycles and one drain cycle where the last write is visible.
  assign issue = (state == COPY) && (cnt_q != n_q);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = (n_clamped == '0) ? FINISH : READ;
      READ:    state_nxt = COPY;
      COPY:    if (cnt_q == n_q) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Fast_Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Fast_Clock) begin
    if (Reset) begin
      slot_q    <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      Src_Addr  <= '0;
      Mem_Write <= 1'b0;
      Mem_Addr  <= '0;
      Mem_Data  <= '0;
    end else begin
      Mem_Write <= issue;
      case (state)
        IDLE: begin
          if (Start) begin
            slot_q <= Dst_Slot;
            n_q    <= n_clamped;
            cnt_q  <= '0;
            if (n_clamped != '0) Src_Addr <= Src_Base;
          end
        end
        READ: Src_Addr <= Src_Addr + 1'b1;
        COPY: begin
          Src_Addr <= Src_Addr + 1'b1;
          if (issue) begin
            Mem_Data <= Src_Data;
            Mem_Addr <= {slot_q, cnt_q[SLOT_BITS-1:0]};
            cnt_q    <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy      = (state != IDLE);
  assign Done      = (state == FINISH);
  assign Dbg_State = state;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: storage model, cycle-accurate expectations
// derived from the copy rules, directed plus randomized copies.
module tb_program_loader;
  import program_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [12:0] src_base;
  logic [3:0]  dst_slot;
  logic [9:0]  word_count;
  logic [12:0] src_addr;
  logic [31:0] src_data;
  logic        mem_write;
  logic [12:0] mem_addr;
  logic [31:0] mem_data;
  logic        busy;
  logic        done;
  state_t      dbg_state;

  logic [31:0] storage [8192];

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  // synchronous-read storage: data valid one cycle after the address
  always @(posedge clk) src_data <= storage[src_addr];

  program_loader dut (
    .Fast_Clock (clk),
    .Reset      (reset),
    .Start      (start),
    .Src_Base   (src_base),
    .Dst_Slot   (dst_slot),
    .Word_Count (word_count),
    .Src_Addr   (src_addr),
    .Src_Data   (src_data),
    .Mem_Write  (mem_write),
    .Mem_Addr   (mem_addr),
    .Mem_Data   (mem_data),
    .Busy       (busy),
    .Done       (done),
    .Dbg_State  (dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".src_addr"},  32'(src_addr),  32'd0);
    chk({tag, ".mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, ".mem_data"},  mem_data,       32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".done"},      32'(done),      32'd0);
  endtask

  // One complete copy. Expected per-cycle behaviour comes from the timing rules:
  // Busy in cycles 1..N+3, writes of word k in cycle k+3, Done in N+3 (cycle 1 if N=0).
  // pulse_cyc > 0 re-asserts Start with other operands during that cycle.
  task automatic run_copy(input logic [12:0] base, input logic [3:0] slot,
                          input logic [9:0] wc, input int pulse_cyc, input string tag);
    int n;
    int last;
    int writes;
    logic exp_busy, exp_done, exp_we;
    n      = (wc > 10'd512) ? 512 : int'(wc);
    last   = (n == 0) ? 3 : n + 4;
    writes = 0;
    @(negedge clk);
    start      = 1'b1;
    src_base   = base;
    dst_slot   = slot;
    word_count = wc;
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        src_base   = 13'($urandom);
        dst_slot   = 4'($urandom);
        word_count = 10'($urandom);
      end
      start = (c == pulse_cyc);
      if (n == 0) begin
        exp_busy = (c == 1);
        exp_done = (c == 1);
        exp_we   = 1'b0;
      end else begin
        exp_busy = (c <= n + 3);
        exp_done = (c == n + 3);
        exp_we   = (c >= 3) && (c <= n + 2);
      end
      chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
      chk({tag, ".done"}, 32'(done), 32'(exp_done));
      chk({tag, ".mem_write"}, 32'(mem_write), 32'(exp_we));
      if (c == 1 && n > 0) chk({tag, ".src_addr_first"}, 32'(src_addr), 32'(base));
      if (mem_write) writes++;
      if (exp_we && mem_write) begin
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(slot) * 512 + (c - 3));
        chk({tag, ".mem_data"}, mem_data, storage[(int'(base) + c - 3) % 8192]);
      end
    end
    start = 1'b0;
    chk({tag, ".write_count"}, 32'(writes), 32'(n));
  endtask

  initial begin
    int writes;
    reset      = 1'b1;
    start      = 1'b0;
    src_base   = '0;
    dst_slot   = '0;
    word_count = '0;
    for (int i = 0; i < 8192; i++) storage[i] = $urandom;
    for (int k = 0; k < 16; k++) storage[16'h100 + k] = 32'hA000_0000 + 32'(k);

    // reset, then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_all_zero("idle");
      chk("idle.state", 32'(dbg_state), 32'(IDLE));
    end

    // directed copies
    run_copy(13'h100, SLOT_PROG2, 10'd4, 0, "basic");
    run_copy(13'h000, SLOT_PROG1, 10'd700, 0, "clamp");
    run_copy(13'h1FFE, SLOT_PROG3, 10'd4, 0, "wrap");
    run_copy(13'h055, SLOT_PROG1, 10'd0, 0, "zero");
    run_copy(13'h200, SLOT_PROG2, 10'd12, 2, "ignore_a");
    run_copy(13'h300, SLOT_PROG3, 10'd6, 9, "ignore_b");

    // reset during a 10-word copy
    @(negedge clk);
    start      = 1'b1;
    src_base   = 13'h400;
    dst_slot   = SLOT_PROG1;
    word_count = 10'd10;
    @(posedge clk);
    writes = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk("rst_mid.busy", 32'(busy), 32'd1);
      if (mem_write) writes++;
    end
    chk("rst_mid.writes_before", 32'(writes), 32'd3);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_mid.c6");
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("rst_mid.no_done", 32'(done), 32'd0);
      chk("rst_mid.no_busy", 32'(busy), 32'd0);
    end
    run_copy(13'h400, SLOT_PROG1, 10'd10, 0, "after_rst");

    // randomized copies
    for (int t = 0; t < 8; t++) begin
      run_copy(13'($urandom), 4'($urandom_range(1, 3)), 10'($urandom_range(0, 40)),
               $urandom_range(0, 6), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
